// File: rtl/rv32_barrel_fetch_pkg.sv
// Shared types and defaults for the barrel rv32 fetch slice.
`ifndef RESET_ADDRESS
`define RESET_ADDRESS 32'h0000_0000
`endif

package rv32_pkg;

  localparam int unsigned RV32_DEFAULT_NUM_HARTS = 8;
  localparam int unsigned RV32_DEFAULT_HID_W     = 3;

  typedef logic [31:0]                   rv_pc_cnt_t;
  typedef logic [31:0]                   rv32_instr_t;
  typedef logic [RV32_DEFAULT_HID_W-1:0] rv32_hart_id_t;

  // Hart-id width; a single-hart build still carries a 1-bit id.
  function automatic int unsigned hid_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rv32_barrel_fetch_rr_arbiter.sv
// Combinational round-robin picker: first requester strictly after 'last', wrapping.
module rv32_rr_arbiter
  import rv32_pkg::*;
#(
  parameter  int unsigned N     = RV32_DEFAULT_NUM_HARTS,
  localparam int unsigned IDX_W = hid_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] grant,
  output logic             any_grant
);

  always_comb begin
    int unsigned idx;
    idx       = 0;
    grant     = '0;
    any_grant = 1'b0;
    // Offset 1..N visits every hart once, ending on 'last' itself.
    for (int unsigned i = 1; i <= N; i++) begin
      idx = (32'(last) + i) % N;
      if (!any_grant && req[idx]) begin
        grant     = idx[IDX_W-1:0];
        any_grant = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rv32_barrel_fetch.sv
// Multi-hart instruction fetch: per-hart PCs, round-robin issue, one-cycle BRAM read.
module rv32_barrel_fetch
  import rv32_pkg::*;
#(
  parameter  int unsigned NUM_HARTS   = RV32_DEFAULT_NUM_HARTS,
  parameter  int unsigned PC_W        = 32,
  parameter  int unsigned IMEM_ADDR_W = 12,
  parameter  logic [31:0] RESET_ADDR  = `RESET_ADDRESS,
  localparam int unsigned HID_W       = hid_width(NUM_HARTS)
) (
  input  logic                   rv32_io_clk,
  input  logic                   rv32_io_rst_n,
  input  logic                   rv32_io_program,
  input  logic [NUM_HARTS-1:0]   hart_en,
  input  logic                   stall,
  input  logic                   redirect_valid,
  input  logic [HID_W-1:0]       redirect_hart,
  input  logic [PC_W-1:0]        redirect_pc,
  output logic [IMEM_ADDR_W-1:0] imem_rd_addr,
  input  rv32_instr_t            imem_rd_data,
  output logic                   if_valid,
  output logic [HID_W-1:0]       if_hart,
  output logic [PC_W-1:0]        if_pc,
  output rv32_instr_t            if_instr,
  output logic                   misalign_err
);

  localparam logic [PC_W-1:0]  RST_PC    = PC_W'(RESET_ADDR);
  localparam logic [HID_W-1:0] LAST_RST  = HID_W'(NUM_HARTS - 1);

  logic [PC_W-1:0]  pc_q [NUM_HARTS];
  logic [PC_W-1:0]  pc_d [NUM_HARTS];
  logic [HID_W-1:0] last_hart_q, last_hart_d;
  logic             f1_valid_q, f1_valid_d;
  logic [HID_W-1:0] f1_hart_q, f1_hart_d;
  logic [PC_W-1:0]  f1_pc_q, f1_pc_d;
  logic             misalign_q, misalign_d;

  logic [HID_W-1:0] grant;
  logic             any_grant;
  logic             issue;

  rv32_rr_arbiter #(
    .N (NUM_HARTS)
  ) u_arb (
    .req       (hart_en),
    .last      (last_hart_q),
    .grant     (grant),
    .any_grant (any_grant)
  );

  assign issue = !stall && !rv32_io_program && any_grant;

  // Under stall the held f1 address is re-presented so q keeps matching if_pc.
  assign imem_rd_addr = stall ? f1_pc_q[IMEM_ADDR_W+1:2] : pc_q[grant][IMEM_ADDR_W+1:2];

  always_comb begin
    last_hart_d = last_hart_q;
    f1_valid_d  = f1_valid_q;
    f1_hart_d   = f1_hart_q;
    f1_pc_d     = f1_pc_q;
    misalign_d  = redirect_valid && (redirect_pc[1:0] != 2'b00);

    for (int unsigned h = 0; h < NUM_HARTS; h++) begin
      pc_d[h] = pc_q[h];
      if (issue && grant == HID_W'(h))
        pc_d[h] = pc_q[h] + PC_W'(4);
      if (redirect_valid && redirect_hart == HID_W'(h))
        pc_d[h] = {redirect_pc[PC_W-1:2], 2'b00};
    end

    if (!stall) begin
      if (issue) begin
        f1_valid_d  = 1'b1;
        f1_hart_d   = grant;
        f1_pc_d     = pc_q[grant];
        last_hart_d = grant;
      end else begin
        f1_valid_d  = 1'b0;
      end
    end

    // One squash covers both the held entry (stall) and a same-cycle issue.
    if (redirect_valid && f1_valid_d && f1_hart_d == redirect_hart)
      f1_valid_d = 1'b0;
  end

  always_ff @(posedge rv32_io_clk or negedge rv32_io_rst_n) begin
    if (!rv32_io_rst_n) begin
      for (int unsigned h = 0; h < NUM_HARTS; h++)
        pc_q[h] <= RST_PC;
      last_hart_q <= LAST_RST;
      f1_valid_q  <= 1'b0;
      f1_hart_q   <= '0;
      f1_pc_q     <= RST_PC;
      misalign_q  <= 1'b0;
    end else begin
      for (int unsigned h = 0; h < NUM_HARTS; h++)
        pc_q[h] <= pc_d[h];
      last_hart_q <= last_hart_d;
      f1_valid_q  <= f1_valid_d;
      f1_hart_q   <= f1_hart_d;
      f1_pc_q     <= f1_pc_d;
      misalign_q  <= misalign_d;
    end
  end

  assign if_valid     = f1_valid_q;
  assign if_hart      = f1_hart_q;
  assign if_pc        = f1_pc_q;
  assign if_instr     = imem_rd_data;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_rv32_barrel_fetch.sv
// Scoreboard bench for rv32_barrel_fetch with 4 harts and a BRAM whose word k holds k.
module tb_rv32_barrel_fetch;
  import rv32_pkg::*;

  localparam int unsigned NH  = 4;
  localparam int unsigned HW  = 2;
  localparam int unsigned PCW = 32;
  localparam int unsigned AW  = 12;

  logic           clk     = 1'b0;
  logic           rst_n   = 1'b0;
  logic           prog    = 1'b0;
  logic           stall   = 1'b0;
  logic           rv      = 1'b0;
  logic [NH-1:0]  hart_en = 4'b1111;
  logic [HW-1:0]  rh      = '0;
  logic [PCW-1:0] rpc     = '0;
  logic [AW-1:0]  addr;
  logic [31:0]    rdata   = '0;
  logic           ifv;
  logic [HW-1:0]  ifh;
  logic [PCW-1:0] ifpc;
  logic [31:0]    ifi;
  logic           mis;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [HW-1:0]  h;
    logic [PCW-1:0] pc;
    logic [31:0]    instr;
  } exp_t;

  exp_t sb[$];

  rv32_barrel_fetch #(
    .NUM_HARTS   (NH),
    .PC_W        (PCW),
    .IMEM_ADDR_W (AW),
    .RESET_ADDR  (32'h0)
  ) dut (
    .rv32_io_clk     (clk),
    .rv32_io_rst_n   (rst_n),
    .rv32_io_program (prog),
    .hart_en         (hart_en),
    .stall           (stall),
    .redirect_valid  (rv),
    .redirect_hart   (rh),
    .redirect_pc     (rpc),
    .imem_rd_addr    (addr),
    .imem_rd_data    (rdata),
    .if_valid        (ifv),
    .if_hart         (ifh),
    .if_pc           (ifpc),
    .if_instr        (ifi),
    .misalign_err    (mis)
  );

  always #5 clk = ~clk;

  // BRAM model: word k contains k, one-cycle read latency.
  always @(posedge clk) rdata <= {20'b0, addr};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push(input int unsigned h, input logic [31:0] pc);
    exp_t e;
    e.h     = HW'(h);
    e.pc    = pc;
    e.instr = {20'b0, pc[13:2]};
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: decode accepts whenever if_valid is high and stall is low.
  initial forever begin
    @(negedge clk);
    if (ifv === 1'b1 && stall === 1'b0) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_fetch actual hart=%0d pc=%0h required no fetch", ifh, ifpc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("if_hart", 32'(ifh), 32'(e.h));
        chk("if_pc", ifpc, e.pc);
        chk("if_instr", ifi, e.instr);
      end
    end
  end

  initial begin
    step();
    chk("rst_if_valid", 32'(ifv), 0);
    chk("rst_if_hart", 32'(ifh), 0);
    chk("rst_if_pc", ifpc, 0);
    chk("rst_imem_addr", 32'(addr), 0);
    chk("rst_misalign", 32'(mis), 0);
    rst_n = 1'b1;

    // All harts enabled: 0,1,2,3 at pc 0, then hart 0 at pc 4.
    push(0, 0); step();
    push(1, 0); step();
    push(2, 0); step();
    push(3, 0); step();
    push(0, 4); step();

    // Only harts 0 and 2.
    hart_en = 4'b0101;
    push(2, 4);  step();
    push(0, 8);  step();
    push(2, 8);  step();
    push(0, 12); step();

    // Hart 2 issues at pc 12, then is redirected to 0x40 while held under stall.
    step();
    stall = 1'b1; rv = 1'b1; rh = 2; rpc = 32'h40;
    @(negedge clk);
    chk("held_valid", 32'(ifv), 1);
    chk("held_hart", 32'(ifh), 2);
    chk("held_pc", ifpc, 32'hc);
    step();
    stall = 1'b0; rv = 1'b0;
    @(negedge clk);
    chk("squash_valid", 32'(ifv), 0);
    push(0, 16);    step();
    push(2, 32'h40); step();

    // Redirect hart 0 in the cycle it issues: issue discarded, pointer still advances.
    rv = 1'b1; rh = 0; rpc = 32'h80;
    step();
    rv = 1'b0;
    @(negedge clk);
    chk("discard_valid", 32'(ifv), 0);
    push(2, 32'h44); step();
    push(0, 32'h80); step();
    push(2, 32'h48); step();

    // Three stalled cycles hold everything.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(ifv), 1);
      chk("stall_hart", 32'(ifh), 2);
      chk("stall_pc", ifpc, 32'h48);
      chk("stall_addr", 32'(addr), 32'h12);
      chk("stall_instr", ifi, 32'h12);
      step();
    end
    stall = 1'b0;
    push(0, 32'h84); step();
    push(2, 32'h4c); step();

    // Misaligned redirect of hart 2 while hart 0 issues.
    rv = 1'b1; rh = 2; rpc = 32'h43;
    push(0, 32'h88); step();
    rv = 1'b0;
    @(negedge clk);
    chk("misalign_pulse", 32'(mis), 1);
    push(2, 32'h40); step();
    @(negedge clk);
    chk("misalign_clear", 32'(mis), 0);
    push(0, 32'h8c); step();

    // Programming hold freezes fetch.
    prog = 1'b1;
    step();
    @(negedge clk);
    chk("program_valid", 32'(ifv), 0);
    step();
    prog = 1'b0;
    push(2, 32'h44); step();
    push(0, 32'h90); step();

    // Asynchronous reset between edges.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(ifv), 0);
    chk("async_rst_pc", ifpc, 0);
    chk("async_rst_hart", 32'(ifh), 0);
    chk("async_rst_misalign", 32'(mis), 0);
    step();
    rst_n = 1'b1;
    push(0, 0); step();
    push(2, 0); step();
    push(0, 4); step();

    // Re-enable harts 1 and 3: their PCs were never advanced.
    hart_en = 4'b1111;
    push(1, 0); step();
    push(2, 4); step();
    push(3, 0); step();
    hart_en = 4'b0000;
    step();
    step();
    chk("scoreboard_empty", 32'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
